instruction_fetch: RTL and testbench

- Fetch stage of the 8-bit CPU; sits directly downstream of the assembler-generated program ROM.
- Holds the program counter (PC) and drives the ROM address. Captures the ROM byte into a small prefetch FIFO.
- Presents instructions to the decode stage over a valid/ready handshake. Accepts control-flow redirects (jumps) from the execute stage and flushes stale prefetches.

---
 rtl/instruction_fetch.sv | 126 ++++++++++++
 tb/tb_instruction_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage of the 8-bit CPU. Owns the program counter,
//               drives the program ROM address, buffers fetched bytes in a
//               small circular prefetch FIFO and hands them to decode over a
//               valid/ready handshake. Execute-stage redirects flush the FIFO
//               and reload the PC.
//               Optional feature macro: FETCH_RETIRE_COUNT_EN adds a 16-bit
//               retire_count output counting delivered instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  rom_address,
    input  logic [7:0]  rom_data,
    output logic [7:0]  instr_data,
    output logic [7:0]  instr_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_target
`ifdef FETCH_RETIRE_COUNT_EN
    ,
    output logic [15:0] retire_count
`endif
);

    // Pointer width is kept at least one bit so DEPTH=1 still elaborates.
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [7:0]         r_pc;
    logic [7:0]         r_fifo_data [DEPTH];
    logic [7:0]         r_fifo_addr [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;

    // Circular pointer advance; the buffer length need not be a power of two.
    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    // Handshake and push qualification. A pop frees a slot in the same cycle,
    // so a full FIFO still accepts a new byte while decode is draining it.
    always_comb begin
        w_full  = (r_count == c_FULL_CNT);
        w_valid = (r_count != '0);
        w_pop   = w_valid & instr_ready;
        w_push  = ~redirect_valid & (~w_full | w_pop);
    end

    // Head presentation; zeros when empty, no bypass from the ROM.
    always_comb begin
        rom_address = r_pc;
        instr_valid = w_valid;
        instr_data  = w_valid ? r_fifo_data[r_rd_ptr] : 8'h00;
        instr_addr  = w_valid ? r_fifo_addr[r_rd_ptr] : 8'h00;
    end

    // PC, pointers and occupancy. A redirect flushes everything and reloads
    // the PC without pushing; the target byte is fetched the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_target;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + 8'd1;
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until the count marks them live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo_data[r_wr_ptr] <= rom_data;
            r_fifo_addr[r_wr_ptr] <= r_pc;
        end
    end

`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] r_retire_count;

    // Count every delivered instruction, including one popped during a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_count <= 16'h0000;
        end else if (w_pop) begin
            r_retire_count <= r_retire_count + 16'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch. Two
//               instances share stimulus: one with the default reset PC and
//               one starting at 8'hFE to cover address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        instr_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_target;

    logic [7:0]  rom_address0, rom_data0, instr_data0, instr_addr0;
    logic        instr_valid0;
    logic [7:0]  rom_address1, rom_data1, instr_data1, instr_addr1;
    logic        instr_valid1;
`ifdef FETCH_RETIRE_COUNT_EN
    logic [15:0] retire_count0;
    logic [15:0] retire_count1;
`endif

    logic [7:0]  rom [256];

    int          n_cmp;
    int          n_err;

    assign rom_data0 = rom[rom_address0];
    assign rom_data1 = rom[rom_address1];

    instruction_fetch #(.RESET_PC(8'h00), .DEPTH(2)) dut0 (
        .clk             (clk),
        .rst             (rst),
        .rom_address     (rom_address0),
        .rom_data        (rom_data0),
        .instr_data      (instr_data0),
        .instr_addr      (instr_addr0),
        .instr_valid     (instr_valid0),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
`ifdef FETCH_RETIRE_COUNT_EN
        ,
        .retire_count    (retire_count0)
`endif
    );

    instruction_fetch #(.RESET_PC(8'hFE), .DEPTH(2)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .rom_address     (rom_address1),
        .rom_data        (rom_data1),
        .instr_data      (instr_data1),
        .instr_addr      (instr_addr1),
        .instr_valid     (instr_valid1),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
`ifdef FETCH_RETIRE_COUNT_EN
        ,
        .retire_count    (retire_count1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp = n_cmp + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the head of dut0 against the ROM model at a given address.
    task automatic chk_head0(input string tag, input logic [7:0] a);
        chk({tag, ".valid"}, {15'd0, instr_valid0}, 16'd1);
        chk({tag, ".addr"},  {8'd0, instr_addr0},   {8'd0, a});
        chk({tag, ".data"},  {8'd0, instr_data0},   {8'd0, rom[a]});
    endtask

    task automatic chk_empty0(input string tag);
        chk({tag, ".valid"}, {15'd0, instr_valid0}, 16'd0);
        chk({tag, ".addr"},  {8'd0, instr_addr0},   16'd0);
        chk({tag, ".data"},  {8'd0, instr_data0},   16'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        // Counting program: even addresses 30,31,32..., odd addresses 86.
        for (int i = 0; i < 256; i++) begin
            rom[i] = (i % 2 == 0) ? 8'(8'h30 + (i / 2)) : 8'h86;
        end
        rom[8'h15] = 8'hC4;

        rst             = 1'b1;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk_empty0("rst");
        chk("rst.pc0", {8'd0, rom_address0}, 16'h0000);
        chk("rst.pc1", {8'd0, rom_address1}, 16'h00FE);
        chk("rst.valid1", {15'd0, instr_valid1}, 16'd0);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("rst.retire", retire_count0, 16'h0000);
`endif

        // ---------------- streaming and wrap ----------------
        rst = 1'b0;
        chk("rel.valid", {15'd0, instr_valid0}, 16'd0);
        tick();
        begin
            logic [7:0] a0;
            logic [7:0] a1;
            a0 = 8'h00;
            a1 = 8'hFE;
            for (int i = 0; i < 6; i++) begin
                chk_head0("stream", a0);
                chk("wrap.valid", {15'd0, instr_valid1}, 16'd1);
                chk("wrap.addr",  {8'd0, instr_addr1}, {8'd0, a1});
                chk("wrap.data",  {8'd0, instr_data1}, {8'd0, rom[a1]});
                a0 = a0 + 8'd1;
                a1 = a1 + 8'd1;
                tick();
            end
        end

        // ---------------- backpressure ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        instr_ready = 1'b0;
        tick();
        chk_head0("bp.first", 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_head0("bp.hold", 8'h00);
            chk("bp.pc", {8'd0, rom_address0}, 16'h0002);
        end
        instr_ready = 1'b1;
        chk_head0("bp.rel0", 8'h00);
        tick();
        chk_head0("bp.rel1", 8'h01);
        tick();
        chk_head0("bp.rel2", 8'h02);
        tick();
        chk_head0("bp.rel3", 8'h03);

        // ---------------- reset while full ----------------
        instr_ready = 1'b0;
        tick();
        tick();
        chk("full.valid", {15'd0, instr_valid0}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_empty0("midrst");
        chk("midrst.pc", {8'd0, rom_address0}, 16'h0000);
        instr_ready = 1'b1;
        tick();
        chk_head0("midrst.h0", 8'h00);
        tick();
        chk_head0("midrst.h1", 8'h01);

        // ---------------- redirect with concurrent pop ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8'h15; i++) tick();
        chk_head0("redir.pre", 8'h15);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("redir.retire0", retire_count0, 16'd21);
`endif
        redirect_valid  = 1'b1;
        redirect_target = 8'h00;
        tick();
        redirect_valid = 1'b0;
        chk_empty0("redir.gap");
        chk("redir.pc", {8'd0, rom_address0}, 16'h0000);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("redir.retire1", retire_count0, 16'd22);
`endif
        tick();
        chk_head0("redir.h0", 8'h00);
        tick();
        chk_head0("redir.h1", 8'h01);
        tick();
        tick();
        tick();
        chk_head0("redir.h4", 8'h04);
`ifdef FETCH_RETIRE_COUNT_EN
        chk("redir.retire2", retire_count0, 16'd26);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.retire", retire_count0, 16'h0000);
        tick();
`endif

        // ---------------- back-to-back redirects ----------------
        redirect_valid  = 1'b1;
        redirect_target = 8'h10;
        tick();
        redirect_target = 8'h20;
        tick();
        redirect_valid = 1'b0;
        chk_empty0("b2b.gap");
        chk("b2b.pc", {8'd0, rom_address0}, 16'h0020);
        tick();
        chk_head0("b2b.h0", 8'h20);
        tick();
        chk_head0("b2b.h1", 8'h21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
